// File: rtl/lbist_pkg.sv
// Shared types and constants for the logic-BIST controller: FSM encoding,
// PRPG tap positions and the default MISR polynomial.
package lbist_pkg;

  localparam int SIG_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } lbist_state_e;

  // Fibonacci PRPG taps; feedback enters at bit 0 as the register shifts up
  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  localparam logic [SIG_W-1:0] MISR_POLY_DEFAULT = 32'h0040_0007;

  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] cur);
    return {cur[SIG_W-2:0],
            cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register: compacts a narrow response word into a
// 32-bit signature when enabled; synchronous clear has priority over enable.
module lbist_misr
  import lbist_pkg::*;
#(
  parameter int                IN_W = 8,
  parameter logic [SIG_W-1:0]  POLY = MISR_POLY_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [IN_W-1:0]   data_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] misr_reg;
  logic [SIG_W-1:0] misr_next;
  logic [SIG_W-1:0] data_ext;

  always_comb begin
    data_ext = '0;
    data_ext[IN_W-1:0] = data_i;
    misr_next = (misr_reg << 1) ^ ({SIG_W{misr_reg[SIG_W-1]}} & POLY) ^ data_ext;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misr_reg <= '0;
    end else if (clr_i) begin
      misr_reg <= '0;
    end else if (en_i) begin
      misr_reg <= misr_next;
    end
  end

  assign sig_o = misr_reg;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: PRPG load, functional capture and MISR unload over
// N_PATTERNS patterns, then a golden-signature compare.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int               N_CHAINS   = 8,
  parameter int               CHAIN_LEN  = 64,
  parameter int               N_PATTERNS = 1024,
  parameter logic [SIG_W-1:0] LFSR_SEED  = 32'hACE1_0001,
  parameter logic [SIG_W-1:0] MISR_POLY  = MISR_POLY_DEFAULT,
  localparam int              PC_W       = $clog2(N_PATTERNS + 1),
  localparam int              SC_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [SIG_W-1:0]    golden_sig_i,
  input  logic [N_CHAINS-1:0] scan_out_i,
  output logic [N_CHAINS-1:0] scan_in_o,
  output logic                scan_en_o,
  output logic                capture_o,
  output logic                test_mode_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [SIG_W-1:0]    signature_o,
  output logic [PC_W-1:0]     pattern_cnt_o
);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("lbist_ctrl: LFSR_SEED must be non-zero");
  end
  if (N_CHAINS < 1 || N_CHAINS > SIG_W) begin : g_bad_chains
    $error("lbist_ctrl: N_CHAINS must be in 1..32");
  end
  if (CHAIN_LEN < 1 || N_PATTERNS < 1) begin : g_bad_lengths
    $error("lbist_ctrl: CHAIN_LEN and N_PATTERNS must be at least 1");
  end

  lbist_state_e     state_reg, state_next;
  logic [SC_W-1:0]  shift_cnt_reg;
  logic [PC_W-1:0]  pattern_cnt_reg;
  logic [SIG_W-1:0] lfsr_reg;
  logic             pass_reg;
  logic             last_shift;
  logic             last_pattern;
  logic             run_active;
  logic             misr_en;
  logic             misr_clr;

  assign last_shift   = (shift_cnt_reg == SC_W'(CHAIN_LEN - 1));
  assign last_pattern = ((pattern_cnt_reg + PC_W'(1)) == PC_W'(N_PATTERNS));
  assign run_active   = (state_reg != IDLE) && (state_reg != DONE);

  always_comb begin
    state_next = state_reg;
    if (abort_i && run_active) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (start_i) state_next = INIT;
        INIT:    state_next = SHIFT;
        SHIFT:   if (last_shift) state_next = CAPTURE;
        CAPTURE: state_next = last_pattern ? UNLOAD : SHIFT;
        UNLOAD:  if (last_shift) state_next = COMPARE;
        COMPARE: state_next = DONE;
        DONE:    if (start_i) state_next = INIT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      shift_cnt_reg   <= '0;
      pattern_cnt_reg <= '0;
      lfsr_reg        <= LFSR_SEED;
      pass_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Counter restarts on every phase change, saturates at the last shift
      if (state_next != state_reg) begin
        shift_cnt_reg <= '0;
      end else if (!last_shift) begin
        shift_cnt_reg <= shift_cnt_reg + SC_W'(1);
      end
      unique case (state_reg)
        INIT: begin
          lfsr_reg        <= LFSR_SEED;
          pattern_cnt_reg <= '0;
          pass_reg        <= 1'b0;
        end
        SHIFT:   lfsr_reg <= lfsr_step(lfsr_reg);
        CAPTURE: pattern_cnt_reg <= pattern_cnt_reg + PC_W'(1);
        COMPARE: pass_reg <= (signature_o == golden_sig_i);
        default: ;
      endcase
    end
  end

  // The first unload only flushes unknown chain contents, so it is not compacted
  assign misr_en  = ((state_reg == SHIFT) && (pattern_cnt_reg != '0)) || (state_reg == UNLOAD);
  assign misr_clr = (state_reg == INIT);

  lbist_misr #(
    .IN_W (N_CHAINS),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (misr_clr),
    .en_i   (misr_en),
    .data_i (scan_out_i),
    .sig_o  (signature_o)
  );

  assign scan_in_o     = (state_reg == SHIFT) ? lfsr_reg[N_CHAINS-1:0] : '0;
  assign scan_en_o     = (state_reg == SHIFT) || (state_reg == UNLOAD);
  assign capture_o     = (state_reg == CAPTURE);
  assign test_mode_o   = run_active;
  assign busy_o        = run_active;
  assign done_o        = (state_reg == DONE);
  assign pass_o        = (state_reg == DONE) && pass_reg;
  assign pattern_cnt_o = pattern_cnt_reg;

endmodule
